// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter: serialises data and instruction requests onto one RAM port, data first.
// Optional RAM watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module memory_arbiter #(
    parameter int WORD_W      = 32,
    parameter int RAM_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DATA, INSTR} stateT;

    stateT state;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(RAM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RAM_TIMEOUT - 1);

    logic [TO_W-1:0] toCount;
`else
    logic unusedTimeout;
    assign unusedTimeout = (RAM_TIMEOUT > 0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            imemload <= '0;
            dmemload <= '0;
            err      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            toCount  <= '0;
`endif
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    // A hit this cycle means the requester has not dropped its strobe yet.
                    if (!(ihit || dhit)) begin
                        if (dmemWEN || dmemREN) begin
                            state    <= DATA;
                            ramaddr  <= dmemaddr;
                            ramstore <= dmemstore;
                            ramWEN   <= dmemWEN;
                            ramREN   <= !dmemWEN;
`ifdef MEM_ARB_TIMEOUT_EN
                            toCount  <= '0;
`endif
                        end else if (imemREN) begin
                            state   <= INSTR;
                            ramaddr <= imemaddr;
                            ramWEN  <= 1'b0;
                            ramREN  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                            toCount <= '0;
`endif
                        end
                    end
                end
                DATA, INSTR: begin
                    if (ramstate == RAM_ACCESS) begin
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (state == DATA) begin
                            dhit <= 1'b1;
                            if (!ramWEN) dmemload <= ramload;
                        end else begin
                            ihit     <= 1'b1;
                            imemload <= ramload;
                        end
                    end else if (ramstate == RAM_ERROR) begin
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        err    <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (toCount == TO_LAST) begin
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        toCount <= toCount + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter; the RAM side is driven cycle by cycle from each test task.
module tb_memory_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int tests = 0;
    int fails = 0;

    memory_arbiter #(.WORD_W(32), .RAM_TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        tests++; if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b, want 00000", {ihit, dhit, ramREN, ramWEN, err});
        end
        tests++; if ({ramaddr, ramstore} !== 64'h0) begin
            fails++; $display("FAIL reset_ramaddr_store: got %h, want 0", {ramaddr, ramstore});
        end
        tests++; if ({imemload, dmemload} !== 64'h0) begin
            fails++; $display("FAIL reset_loads: got %h, want 0", {imemload, dmemload});
        end
        RST = 1'b0;
    endtask

    task automatic test_fetch();
        int reCycles = 0;
        int hitCount = 0;
        imemREN = 1'b1; imemaddr = 32'h40; ramstate = BUSY;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (ramREN) reCycles++;
            if (ihit) hitCount++;
            tests++; if (ramaddr !== 32'h40) begin
                fails++; $display("FAIL fetch_ramaddr: got %h, want 00000040", ramaddr);
            end
            ramstate = (i == 3) ? ACCESS : BUSY;
            ramload  = (i == 3) ? 32'h8C010004 : 32'hFFFFFFFF;
        end
        @(negedge CLK);
        if (ihit) hitCount++;
        if (ramREN) reCycles++;
        tests++; if (ihit !== 1'b1 || dhit !== 1'b0) begin
            fails++; $display("FAIL fetch_hit: got ihit=%b dhit=%b, want ihit=1 dhit=0", ihit, dhit);
        end
        tests++; if (imemload !== 32'h8C010004) begin
            fails++; $display("FAIL fetch_imemload: got %h, want 8c010004", imemload);
        end
        ramstate = FREE;
        // imemREN still high through the hit cycle and the cooldown edge
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (ramREN) reCycles++;
            if (ihit) hitCount++;
            if (i == 0) imemREN = 1'b0;
        end
        tests++; if (reCycles != 4) begin
            fails++; $display("FAIL fetch_ramREN_cycles: got %0d, want 4", reCycles);
        end
        tests++; if (hitCount != 1) begin
            fails++; $display("FAIL fetch_ihit_pulses: got %0d, want 1", hitCount);
        end
    endtask

    task automatic test_priority();
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h80;
        dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
        @(negedge CLK);
        tests++; if ({ramWEN, ramREN} !== 2'b10 || ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin
            fails++; $display("FAIL prio_write_grant: got wen=%b ren=%b addr=%h store=%h, want 1 0 00000100 deadbeef",
                              ramWEN, ramREN, ramaddr, ramstore);
        end
        ramstate = ACCESS;
        @(negedge CLK);
        tests++; if (dhit !== 1'b1 || ihit !== 1'b0 || ramWEN !== 1'b0) begin
            fails++; $display("FAIL prio_dhit: got dhit=%b ihit=%b wen=%b, want 1 0 0", dhit, ihit, ramWEN);
        end
        dmemWEN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tests++; if (ramREN !== 1'b0 || dhit !== 1'b0) begin
            fails++; $display("FAIL prio_cooldown: got ren=%b dhit=%b, want 0 0", ramREN, dhit);
        end
        @(negedge CLK);
        tests++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h80) begin
            fails++; $display("FAIL prio_fetch_grant: got ren=%b wen=%b addr=%h, want 1 0 00000080", ramREN, ramWEN, ramaddr);
        end
        ramstate = ACCESS; ramload = 32'h12345678;
        @(negedge CLK);
        tests++; if (ihit !== 1'b1 || imemload !== 32'h12345678 || dmemload !== 32'h0) begin
            fails++; $display("FAIL prio_ihit: got ihit=%b imemload=%h dmemload=%h, want 1 12345678 00000000",
                              ihit, imemload, dmemload);
        end
        imemREN = 1'b0; ramstate = FREE;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_error();
        dmemREN = 1'b1; dmemaddr = 32'h200; ramstate = BUSY;
        @(negedge CLK);
        tests++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200) begin
            fails++; $display("FAIL err_grant: got ren=%b wen=%b addr=%h, want 1 0 00000200", ramREN, ramWEN, ramaddr);
        end
        ramstate = ERROR; ramload = 32'h00000BAD;
        @(negedge CLK);
        tests++; if (err !== 1'b1 || ramREN !== 1'b0 || dhit !== 1'b0 || dmemload !== 32'h0) begin
            fails++; $display("FAIL err_abort: got err=%b ren=%b dhit=%b dmemload=%h, want 1 0 0 00000000",
                              err, ramREN, dhit, dmemload);
        end
        ramstate = FREE;
        @(negedge CLK);
        tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin
            fails++; $display("FAIL err_retry_grant: got ren=%b addr=%h, want 1 00000200", ramREN, ramaddr);
        end
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        @(negedge CLK);
        tests++; if (dhit !== 1'b1 || dmemload !== 32'hCAFEF00D || err !== 1'b1) begin
            fails++; $display("FAIL err_retry_hit: got dhit=%b dmemload=%h err=%b, want 1 cafef00d 1", dhit, dmemload, err);
        end
        dmemREN = 1'b0; ramstate = FREE;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        imemREN = 1'b1; imemaddr = 32'h44; ramstate = BUSY;
        repeat (2) @(negedge CLK);
        tests++; if (ramREN !== 1'b1) begin
            fails++; $display("FAIL rstmid_busy: got ren=%b, want 1", ramREN);
        end
        RST = 1'b1;
        @(negedge CLK);
        tests++; if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0 || {ramaddr, ramstore, imemload, dmemload} !== 128'h0) begin
            fails++; $display("FAIL rstmid_outputs: got ctrl=%b addr=%h load=%h/%h, want 00000 0 0/0",
                              {ihit, dhit, ramREN, ramWEN, err}, ramaddr, imemload, dmemload);
        end
        RST = 1'b0; imemREN = 1'b0; ramstate = ACCESS;
        repeat (2) @(negedge CLK);
        tests++; if (ihit !== 1'b0 || ramREN !== 1'b0) begin
            fails++; $display("FAIL rstmid_no_hit: got ihit=%b ren=%b, want 0 0", ihit, ramREN);
        end
        ramstate = FREE;
    endtask

    task automatic test_timeout();
        int reCycles = 0;
        dmemREN = 1'b1; dmemaddr = 32'h300; ramstate = BUSY;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (ramREN) reCycles++;
        end
        tests++; if (reCycles != 8) begin
            fails++; $display("FAIL timeout_strobe_cycles: got %0d, want 8", reCycles);
        end
`ifdef MEM_ARB_TIMEOUT_EN
        @(negedge CLK);
        tests++; if (err !== 1'b1 || ramREN !== 1'b0 || dhit !== 1'b0) begin
            fails++; $display("FAIL timeout_abort: got err=%b ren=%b dhit=%b, want 1 0 0", err, ramREN, dhit);
        end
        dmemREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tests++; if (dhit !== 1'b0 || ramREN !== 1'b0) begin
            fails++; $display("FAIL timeout_no_hit: got dhit=%b ren=%b, want 0 0", dhit, ramREN);
        end
`else
        repeat (12) @(negedge CLK);
        tests++; if (ramREN !== 1'b1 || err !== 1'b0 || dhit !== 1'b0) begin
            fails++; $display("FAIL wait_forever: got ren=%b err=%b dhit=%b, want 1 0 0", ramREN, err, dhit);
        end
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        @(negedge CLK);
        tests++; if (dhit !== 1'b1 || dmemload !== 32'h0BADF00D) begin
            fails++; $display("FAIL wait_late_hit: got dhit=%b dmemload=%h, want 1 0badf00d", dhit, dmemload);
        end
        dmemREN = 1'b0; ramstate = FREE;
`endif
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0;
        ramload = '0; ramstate = FREE;
        test_reset();
        test_fetch();
        test_priority();
        test_error();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-ported RAM arbiter that sits directly downstream of the request unit. It accepts the request unit's `imemREN`, `dmemREN` and `dmemWEN` strobes, serialises them onto one multi-cycle RAM port, and returns the `ihit`/`dhit` pulses plus load data that the request unit and datapath consume. Data accesses take priority over instruction fetches. A sticky error flag reports RAM faults.

## Interface
Parameters:
- `WORD_W`, 32, address/data width
- `RAM_TIMEOUT`, 64, max cycles a granted access may wait for RAM `ACCESS` (used only with `MEM_ARB_TIMEOUT_EN`)

Ports:
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  reset: synchronous, active-high
- `imemREN`  in  1  instruction read request, held until `ihit`
- `imemaddr`  in  WORD_W  fetch address
- `dmemREN`  in  1  data read request, held until `dhit`
- `dmemWEN`  in  1  data write request, held until `dhit`
- `dmemaddr`  in  WORD_W  data address
- `dmemstore`  in  WORD_W  write data
- `ihit`  out  1  one-cycle fetch-complete pulse
- `dhit`  out  1  one-cycle data-complete pulse
- `imemload`  out  WORD_W  fetched word, valid with `ihit`, held until next `ihit`
- `dmemload`  out  WORD_W  read word, valid with `dhit` on reads, held until next read `dhit`
- `ramREN`, `ramWEN`  out  1  RAM strobes
- `ramaddr`, `ramstore`  out  WORD_W  RAM address / write data
- `ramload`  in  WORD_W  RAM read data
- `ramstate`  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- `err`  out  1  sticky fault flag

## Operation
- FSM states: IDLE, DATA, INSTR.
- IDLE: if `ihit|dhit` is high this cycle, no grant (cooldown; request unit is still dropping its strobe). Otherwise `dmemWEN|dmemREN` -> DATA; else `imemREN` -> INSTR; else stay.
- On grant, register address, store data and op (write if `dmemWEN`, which beats `dmemREN` when both are high). RAM strobes are driven only from registered values, never combinationally from inputs.
- DATA/INSTR: hold strobes until `ramstate==ACCESS`.
  - On ACCESS: capture `ramload` for reads, pulse the matching hit next cycle, return to IDLE.
  - On `ramstate==ERROR`: set `err`, drop strobes, return to IDLE with no hit.
  - BUSY/FREE: wait.
- An instruction request is never pre-empted once granted. A data request arriving mid-fetch is granted on the first non-cooldown IDLE cycle.
- `err` clears only on `RST`.

## Timing
- Reset values: `ihit=dhit=0`, `ramREN=ramWEN=0`, `ramaddr=ramstore=0`, `imemload=dmemload=0`, `err=0`, state IDLE.
- Request seen in IDLE at edge N -> RAM strobes high from N+1.
- ACCESS sampled at edge M -> hit high for cycle M+1 only, strobes low from M+1.
- Minimum latency from request to hit is 2 cycles (ACCESS on the first strobe cycle).
- Back-to-back: next grant is no earlier than one cycle after the hit cycle.
- `RST` mid-access: strobes low and state IDLE after the next edge. No hit is produced for the aborted access.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined: a counter clears on grant and increments each DATA/INSTR cycle without ACCESS. Reaching `RAM_TIMEOUT` sets `err`, drops strobes and returns to IDLE with no hit.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter. The arbiter waits indefinitely for ACCESS or ERROR.

## Test plan
- Fetch `imemaddr=0x40` with RAM ACCESS after 3 BUSY cycles, `ramload=0x8C010004` -> `ramREN` high 4 cycles, `ihit` single pulse, `imemload=0x8C010004`, `dhit` stays 0.
- `imemREN` and `dmemWEN` raised in the same cycle, `dmemaddr=0x100`, `dmemstore=0xDEADBEEF` -> write serviced first (`ramWEN`, `ramstore=0xDEADBEEF`), `dhit` pulse, then fetch, then `ihit`.
- Request held high through its hit cycle -> exactly one hit pulse and no second RAM access.
- `ramstate=ERROR` during a data read -> `err=1` sticky, no `dhit`, strobes low next cycle; the next request is still serviced normally.
- `RST` asserted two cycles into a BUSY access -> all outputs at reset values after the edge.
- With `MEM_ARB_TIMEOUT_EN` and `RAM_TIMEOUT=8`, RAM held BUSY -> `err` set after 8 strobe cycles, no hit. Without the macro, strobes stay high indefinitely.
